ifetch_prefetch_unit: RTL and testbench
=======================================

IFETCH_PREFETCH_UNIT -- requirements
Module: ifetch_prefetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width in bits.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width in bits; a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; a power of 2 and at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port fetch_en, input, 1 bit: permits issue of new requests.
REQ-008 SHALL have port mem_req_valid, output, 1 bit: fetch request valid.
REQ-009 SHALL have port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 SHALL have port mem_req_addr, output, ADDR_W bits: fetch address.
REQ-011 SHALL have port mem_rsp_valid, input, 1 bit: instruction return, in order, one per accepted request.
REQ-012 SHALL have port mem_rsp_data, input, INSTR_W bits: returned instruction.
REQ-013 SHALL have port redirect_valid, input, 1 bit: branch or exception redirect.
REQ-014 SHALL have port redirect_pc, input, ADDR_W bits: new fetch address.
REQ-015 SHALL have port dec_valid, output, 1 bit: queue head valid toward decode.
REQ-016 SHALL have port dec_ready, input, 1 bit: decode accepts the head.
REQ-017 SHALL have port dec_instr, output, INSTR_W bits: head instruction.
REQ-018 SHALL have port dec_pc, output, ADDR_W bits: head instruction address.

Function
REQ-019 SHALL implement an FSM with states IDLE, FETCH and DRAIN.
- IDLE->FETCH on the first edge after reset release.
- FETCH->DRAIN on redirect while responses are outstanding.
- DRAIN->FETCH when the drop counter reaches 0.
REQ-020 SHALL assert mem_req_valid only when all of the following hold: state is FETCH, fetch_en=1, redirect_valid=0, and outstanding+occupancy<DEPTH.
REQ-021 SHALL hold mem_req_valid and mem_req_addr stable until accepted; the only permitted withdrawal is on redirect_valid.
REQ-022 SHALL advance pc by INSTR_W/8 on each accepted request (mem_req_valid & mem_req_ready), wrapping modulo 2^ADDR_W.
REQ-023 SHALL write each non-dropped response with its pc into the queue at the edge of mem_rsp_valid; dec_valid rises the following cycle.
REQ-024 SHALL pop the queue on dec_valid & dec_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-025 SHALL never overflow the queue: the credit rule in REQ-020 guarantees space, and a response arriving with the queue full is an assertion error.
REQ-026 SHALL give redirect_valid priority over every other event in its cycle:
- pc <= redirect_pc;
- queue flushed, with dec_valid=0 the next cycle;
- drop counter <= outstanding minus mem_rsp_valid;
- a response arriving in the redirect cycle is discarded.
REQ-027 SHALL discard responses while the drop counter is nonzero, decrementing it once per response; no requests issue in DRAIN.
REQ-028 SHALL accept a redirect while in DRAIN, reloading pc and keeping the count of responses still owed.
REQ-029 SHALL keep dec_instr and dec_pc stable while dec_valid=1 and dec_ready=0.
REQ-030 SHALL take 2 cycles minimum from request acceptance to dec_valid with a 1-cycle memory.

Reset
REQ-031 SHALL, while reset=0, hold state IDLE, pc=RESET_PC, queue empty, outstanding=0, drop counter=0, mem_req_valid=0, dec_valid=0, and mem_req_addr, dec_instr, dec_pc all 0.
REQ-032 SHALL, on reset asserted mid-operation, discard all outstanding and queued entries immediately and without waiting for a clock.

Configuration
REQ-033 SHALL, with IFETCH_PERF_CNT_EN defined, add output perf_fetch_cnt (32 bits, counts accepted requests) and perf_stall_cnt (32 bits, counts cycles with dec_valid=0 and state FETCH). Both reset to 0 and wrap at 2^32.
REQ-034 SHALL, without IFETCH_PERF_CNT_EN, omit both ports and their logic entirely.

Verification
REQ-035 SHALL cover reset release with fetch_en=1 and a 1-cycle memory -> requests to 0x0, 0x4, 0x8, 0xC; dec_pc sequence 0x0, 0x4, ... with first dec_valid 2 cycles after the first acceptance.
REQ-036 SHALL cover dec_ready=0 held -> exactly DEPTH=4 requests issue, then mem_req_valid=0; one pop re-enables exactly one request.
REQ-037 SHALL cover a redirect to 0x100 with 2 responses outstanding -> both responses dropped, queue empty, next request address 0x100, first dec_pc=0x100.
REQ-038 SHALL cover redirect and mem_rsp_valid in the same cycle with 1 outstanding -> that response dropped, drop counter 0, FETCH resumes the next cycle.
REQ-039 SHALL cover pc=0xFFFF_FFFC accepted -> next mem_req_addr 0x0000_0000.
REQ-040 SHALL cover reset asserted with 3 queued entries -> dec_valid=0 and mem_req_valid=0 asynchronously; after release, the first request goes to RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: in-order instruction prefetcher with a DEPTH-entry
// queue toward decode, credit-limited issue and post-redirect draining.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   fetch_en            permits issue of new fetch requests
//   mem_req_valid/ready request handshake, mem_req_addr = fetch address
//   mem_rsp_valid/data  in-order instruction return, one per accepted request
//   redirect_valid/pc   branch or exception redirect, wins over all events
//   dec_valid/ready     queue head handshake toward decode
//   dec_instr, dec_pc   queue head instruction and its address
//   perf_fetch_cnt      accepted requests        (IFETCH_PERF_CNT_EN only)
//   perf_stall_cnt      FETCH cycles, head empty (IFETCH_PERF_CNT_EN only)
//
// Optional feature macro: IFETCH_PERF_CNT_EN adds the two perf counters.

module ifetch_prefetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_rsp_valid,
   input  logic [INSTR_W-1:0] mem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  dec_pc
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_stall_cnt
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_W / 8);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   rsp_pc_q, rsp_pc_d;
   logic                pend_q, pend_d;
   logic [CW-1:0]       out_q, out_d;
   logic [CW-1:0]       drop_q, drop_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       wptr_q, wptr_d;
   logic [PW-1:0]       rptr_q, rptr_d;
   logic [INSTR_W-1:0]  q_instr_q [DEPTH];
   logic [ADDR_W-1:0]   q_pc_q    [DEPTH];

   logic credit_ok;
   logic req_valid;
   logic accept;
   logic drop_rsp;
   logic push;
   logic pop;

   // Credits count both in-flight responses and queued entries, so an
   // arriving response always finds a free slot.
   assign credit_ok = (32'(out_q) + 32'(cnt_q)) < DEPTH;

   // Once offered, a request stays up until taken even if fetch_en drops;
   // only a redirect may pull it back.
   assign req_valid = (state_q == ST_FETCH) && !redirect_valid &&
                      (pend_q || (fetch_en && credit_ok));

   assign accept   = req_valid && mem_req_ready;
   assign drop_rsp = mem_rsp_valid && (redirect_valid || (drop_q != '0));
   assign push     = mem_rsp_valid && !drop_rsp;
   assign pop      = dec_valid && dec_ready && !redirect_valid;

   assign mem_req_valid = req_valid;
   assign mem_req_addr  = req_valid ? pc_q : '0;
   assign dec_valid     = (cnt_q != '0);
   assign dec_instr     = dec_valid ? q_instr_q[rptr_q] : '0;
   assign dec_pc        = dec_valid ? q_pc_q[rptr_q] : '0;

   always_comb begin
      out_d    = out_q + CW'(accept) - CW'(mem_rsp_valid);
      drop_d   = drop_q;
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      pend_d   = req_valid && !mem_req_ready;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      wptr_d   = wptr_q + PW'(push);
      rptr_d   = rptr_q + PW'(pop);
      state_d  = state_q;

      if (redirect_valid) begin
         // Everything still owed belongs to the old stream.
         drop_d   = out_q - CW'(mem_rsp_valid);
         pc_d     = redirect_pc;
         rsp_pc_d = redirect_pc;
         cnt_d    = '0;
         wptr_d   = '0;
         rptr_d   = '0;
      end else begin
         if (mem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (accept) begin
            pc_d = pc_q + STEP;
         end
         // Surviving responses map to consecutive addresses from the
         // last redirect, so the response pc is a running counter.
         if (push) begin
            rsp_pc_d = rsp_pc_q + STEP;
         end
      end

      unique case (1'b1)
         (state_q == ST_IDLE): state_d = ST_FETCH;
         default:              state_d = (drop_d != '0) ? ST_DRAIN
                                                         : ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         pend_q   <= 1'b0;
         out_q    <= '0;
         drop_q   <= '0;
         cnt_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_instr_q[i] <= '0;
            q_pc_q[i]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         pend_q   <= pend_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         if (push) begin
            q_instr_q[wptr_q] <= mem_rsp_data;
            q_pc_q[wptr_q]    <= rsp_pc_q;
         end
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] pfetch_q;
   logic [31:0] pstall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pfetch_q <= '0;
         pstall_q <= '0;
      end else begin
         pfetch_q <= pfetch_q + 32'(accept);
         pstall_q <= pstall_q +
                     32'((state_q == ST_FETCH) && !dec_valid);
      end
   end

   assign perf_fetch_cnt = pfetch_q;
   assign perf_stall_cnt = pstall_q;
`endif

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!reset)
      !(push && (cnt_q == CW'(DEPTH)))
   );

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: directed vector table, corner sequences,
// and randomized traffic against a stream-level reference model.
`timescale 1ns/1ps

module tb_ifetch_prefetch_unit;

   localparam int DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk;
   logic        reset;
   logic        fetch_en;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   ifetch_prefetch_unit #(
      .ADDR_W  (32),
      .INSTR_W (32),
      .DEPTH   (DEPTH),
      .RESET_PC(RST_PC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_instr     (dec_instr),
      .dec_pc        (dec_pc)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned ep;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } qent_t;

   typedef struct {
      bit          fe;
      bit          rdy;
      bit          drdy;
      bit          rv;
      logic [31:0] addr;
      bit          dv;
      logic [31:0] pc;
   } vec_t;

   mreq_t       memq[$];
   qent_t       mq[$];
   int          n_chk;
   int          n_fail;
   int          cyc;
   int          lat;
   int unsigned epoch;
   logic [31:0] mdl_pc;
   bit          pend;
   bit          first;

   function automatic logic [31:0] f(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hA5C3_0F96;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endfunction

   task automatic do_reset();
      reset          = 1'b0;
      fetch_en       = 1'b0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      memq.delete();
      mq.delete();
      epoch  = 0;
      mdl_pc = RST_PC;
      pend   = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_dec_pc", dec_pc, 0);
      chk("rst_dec_instr", dec_instr, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      first = 1'b1;
   endtask

   // One clock cycle: drive at negedge, check 1ns later, then advance
   // the reference model by the events of the coming rising edge.
   task automatic step(input bit fe, input bit rdy, input bit drdy,
                       input bit rd, input logic [31:0] rdpc);
      mreq_t cur;
      bit    cur_v;
      int    stale;
      int    owed;
      bit    exp_rv;
      int    due;
      @(negedge clk);
      cyc++;
      cur_v = 1'b0;
      cur   = '{addr: '0, ep: 0, due: 0};
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         cur   = memq.pop_front();
         cur_v = 1'b1;
      end
      mem_rsp_valid  = cur_v;
      mem_rsp_data   = cur_v ? f(cur.addr) : 32'($urandom);
      fetch_en       = fe;
      mem_req_ready  = rdy;
      dec_ready      = drdy;
      redirect_valid = rd;
      redirect_pc    = rdpc;
      #1;
      stale = (cur_v && cur.ep != epoch) ? 1 : 0;
      foreach (memq[k]) if (memq[k].ep != epoch) stale++;
      owed   = memq.size() + int'(cur_v);
      exp_rv = !first && !rd && stale == 0 &&
               (pend || (fe && (owed + mq.size()) < DEPTH));
      chk("req_valid", mem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", mem_req_addr, mdl_pc);
      chk("dec_valid", dec_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("dec_pc", dec_pc, mq[0].pc);
         chk("dec_instr", dec_instr, mq[0].instr);
      end
      if (mem_req_valid && rdy) begin
         due = cyc + lat;
         if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
         memq.push_back('{addr: mem_req_addr, ep: epoch, due: due});
      end
      if (rd) begin
         mq.delete();
         epoch++;
         mdl_pc = rdpc;
         pend   = 1'b0;
      end else begin
         if (exp_rv && rdy) mdl_pc = mdl_pc + 32'd4;
         pend = exp_rv && !rdy;
         if (mq.size() != 0 && drdy) void'(mq.pop_front());
         if (cur_v && cur.ep == epoch)
            mq.push_back('{pc: cur.addr, instr: f(cur.addr)});
      end
      first = 1'b0;
   endtask

   initial begin
      vec_t        vec[10];
      int          n_acc;
      bit          found;
      logic [31:0] accs[$];

      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vec[10];
      int          n_acc;
      bit          found;
      logic [31:0] accs[$];

      vec[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      vec[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vec[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vec[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vec[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vec[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vec[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      vec[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
      vec[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
      vec[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10};

      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      lat    = 1;

      // Reset release, 1-cycle memory, then decode back-pressure.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(vec[i].fe, vec[i].rdy, vec[i].drdy, 1'b0, 32'h0);
         chk($sformatf("vec%0d_rv", i), mem_req_valid, vec[i].rv);
         if (vec[i].rv) chk($sformatf("vec%0d_addr", i), mem_req_addr,
                            vec[i].addr);
         chk($sformatf("vec%0d_dv", i), dec_valid, vec[i].dv);
         if (vec[i].dv) begin
            chk($sformatf("vec%0d_pc", i), dec_pc, vec[i].pc);
            chk($sformatf("vec%0d_instr", i), dec_instr, f(vec[i].pc));
         end
      end

      // Decode stalled: exactly DEPTH requests, one pop frees one credit.
      do_reset();
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         if (mem_req_valid) n_acc++;
      end
      chk("fill_accepts", n_acc, DEPTH);
      chk("fill_valid_low", mem_req_valid, 0);
      chk("fill_head_pc", dec_pc, 32'h0);
      n_acc = 0;
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (mem_req_valid) n_acc++;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         if (mem_req_valid) n_acc++;
      end
      chk("pop_reissue", n_acc, 1);

      // Redirect with two responses outstanding.
      do_reset();
      lat = 3;
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
      chk("redir_req_low", mem_req_valid, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("drain1_req_low", mem_req_valid, 0);
      chk("drain1_dec_low", dec_valid, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("drain2_req_low", mem_req_valid, 0);
      chk("drain2_dec_low", dec_valid, 0);
      lat = 1;
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("post_drain_valid", mem_req_valid, 1);
      chk("post_drain_addr", mem_req_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         if (dec_valid) begin
            found = 1'b1;
            chk("redir_first_pc", dec_pc, 32'h100);
         end
      end
      chk("redir_dec_seen", found, 1);

      // Redirect coinciding with the only outstanding response.
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
      chk("same_cyc_req_low", mem_req_valid, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("same_cyc_resume", mem_req_valid, 1);
      chk("same_cyc_addr", mem_req_addr, 32'h200);
      chk("same_cyc_dec_low", dec_valid, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("same_cyc_dv", dec_valid, 1);
      chk("same_cyc_pc", dec_pc, 32'h200);

      // Address wrap at the top of the address space.
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      accs.delete();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         if (mem_req_valid) accs.push_back(mem_req_addr);
      end
      chk("wrap_count_ok", accs.size() >= 3, 1);
      if (accs.size() >= 3) begin
         chk("wrap_a0", accs[0], 32'hFFFF_FFF8);
         chk("wrap_a1", accs[1], 32'hFFFF_FFFC);
         chk("wrap_a2", accs[2], 32'h0000_0000);
      end

      // Asynchronous reset with three queued entries.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("q3_dec_valid", dec_valid, 1);
      #1 reset = 1'b0;
      #1;
      chk("async_dec_valid", dec_valid, 0);
      chk("async_req_valid", mem_req_valid, 0);
      chk("async_dec_pc", dec_pc, 0);
      chk("async_dec_instr", dec_instr, 0);
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("post_rst_valid", mem_req_valid, 1);
      chk("post_rst_addr", mem_req_addr, RST_PC);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) lat = $urandom_range(1, 3);
         if (i == 1500) do_reset();
         step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
              32'($urandom) & 32'hFFFF_FFFC);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
